pulse_gate_gen: RTL
===================

Name: pulse_gate_gen

Overview:
- Inverse of the button edge-detector: converts single-cycle trigger pulses (key-press events) into a held gate level of programmable length.
- Feeds synth voice/envelope logic and LED indicators.
- Guarantees a minimum low gap between gates, so downstream edge-detectors always see distinct presses.
- Supports retrigger (extend the gate) and, optionally, queuing of triggers that arrive while busy.

Parameters:
- LEN_W, 8, width of len input and internal gate counter.
- GAP, 2, number of forced gate-low cycles after every gate (must be ≥1).
- Q_W, 2, width of pending-trigger counter (optional queue only; max pending = 2^Q_W-1).

Ports:
- clk  input  1  system clock; all state on posedge.
- reset  input  1  synchronous, active-high reset.
- trig  input  1  trigger event; each high cycle is one event.
- len  input  LEN_W  gate length in cycles, sampled with the accepted trig; 0 treated as 1.
- retrig_en  input  1  1: trig during GATE reloads the length; 0: trig during GATE not accepted.
- gate  output  1  held gate level, registered.
- gate_start  output  1  one-cycle pulse in the first gate-high cycle of each new gate, registered.
- busy  output  1  high whenever state ≠ IDLE, registered.
- dropped  output  1  one-cycle pulse in the cycle after a trig that was discarded.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: state=IDLE, counters=0, gate=0, gate_start=0, busy=0, dropped=0. Applies on the next edge from any state; a gate in progress is cut with no gap enforced.
- States: IDLE, GATE, GAP.
- IDLE:
  - trig sampled high at the edge ending cycle n → GATE.
  - Counter loads L = max(len,1).
  - gate=1 in cycles n+1 .. n+L; gate_start=1 in cycle n+1 only.
- GATE:
  - Counter decrements each cycle.
  - On the last gate cycle (no accepted retrigger) → GAP; gate=0 for exactly GAP cycles.
- GATE with trig and retrig_en=1:
  - Counter reloads with max(len,1) counted from that cycle: trig in cycle m → gate high through cycle m+L.
  - No new gate_start.
  - Also applies on the last gate cycle, so the gate is extended with no low cycle.
- GATE with trig and retrig_en=0: trig not accepted (queued if the feature is on, otherwise dropped).
- GAP:
  - trig not accepted (queued or dropped).
  - After GAP cycles → IDLE.
  - A trig in the first IDLE cycle is accepted normally.
- dropped is high in cycle m+1 for each discarded trig in cycle m.
- len is ignored except at acceptance/reload. Changes mid-gate do not affect the current count.
- busy: high from the first gate cycle through the last GAP cycle.
- trig held high continuously:
  - Each cycle is a separate event.
  - retrig_en=1: gate stays high indefinitely.
  - retrig_en=0: one gate per GATE+GAP period, with dropped pulses while not accepted (feature off).

Optional Feature:
- Macro: PULSE_GATE_QUEUE_EN.
- Defined:
  - A pending counter (Q_W bits) increments on each non-accepted trig.
  - If the counter is saturated at 2^Q_W-1, the trig is dropped and dropped pulses.
  - On the last GAP cycle, if pending>0: go directly to GATE with the current len, pulse gate_start, decrement pending. The gate rises in the cycle that would have been the first IDLE cycle.
  - A trig in the same last-GAP cycle increments pending in the same edge (net change 0).
  - Reset clears pending.
- Undefined: no pending counter; every non-accepted trig is dropped.
- Ports are identical in both builds.

Test Plan:
1. LEN_W=8, GAP=2; reset cycles 0–1; trig cycle 5, len=4 → gate high 6–9; gate_start only in 6; busy 6–11; busy=0 at 12; dropped never high.
2. trig cycle 5, len=0 → gate high only in cycle 6; GAP 7–8; IDLE at 9.
3. retrig_en=1, len=4, trig in cycles 5 and 8 → gate high 6–12 continuous; single gate_start at 6; GAP 13–14.
4. retrig_en=0, len=4, trig in cycles 5 and 8 → gate 6–9; dropped in cycle 9; no second gate_start.
5. len=4, trig 5 and trig 10 (GAP):
   - Macro off → dropped at 11; gate stays 0 from 10 onward.
   - Macro on → gate_start at 12; gate 12–15.
   - Q_W=2 with 4 extra trigs during gate (retrig_en=0) → 4th gives dropped; exactly 3 queued gates follow, each separated by 2 low cycles.
6. len=10, trig 5; reset high in cycle 8 → gate, busy, gate_start all 0 from cycle 9; trig at 10 with reset low → new gate_start at 11.

Source files
------------

// File: rtl/pulse_gate_gen_if.sv
// pulse_gate_gen_if: trigger-side inputs and gate-side outputs of the pulse
// gate generator. The master drives triggers; the slave (the generator)
// returns the gate level and status pulses.
interface pulse_gate_gen_if #(
  parameter int LEN_W = 8
);
  logic             trig;
  logic [LEN_W-1:0] len;
  logic             retrig_en;
  logic             gate;
  logic             gate_start;
  logic             busy;
  logic             dropped;

  modport master (
    output trig, len, retrig_en,
    input  gate, gate_start, busy, dropped
  );

  modport slave (
    input  trig, len, retrig_en,
    output gate, gate_start, busy, dropped
  );
endinterface

// File: rtl/pulse_gate_gen.sv
// pulse_gate_gen: turns single-cycle trigger events into a held gate of
// programmable length, followed by a forced low gap of GAP cycles so that
// downstream edge detectors always see distinct presses.
// Optional macro PULSE_GATE_QUEUE_EN: triggers that arrive while a gate
// cannot accept them are counted and replayed as new gates after the gap.
// Without the macro every non-accepted trigger is discarded with a pulse on
// dropped.
module pulse_gate_gen #(
  parameter int LEN_W = 8,
  parameter int GAP   = 2,
  parameter int Q_W   = 2
) (
  input  logic clk,
  input  logic reset,
  pulse_gate_gen_if.slave bus
);

  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATE,
    S_GAP
  } state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_cnt;       // gate cycles still to go after the current one
  logic [GAP_W-1:0] r_gap_cnt;   // gap cycles still to go after the current one
  logic [Q_W-1:0]   r_pend;      // triggers waiting for a gate (stays 0 without the queue)
  logic             r_gate;
  logic             r_gate_start;
  logic             r_busy;
  logic             r_dropped;

  logic [LEN_W-1:0] w_load;
  logic             w_nonacc;
  logic             w_q_full;
  logic             w_q_inc;
  logic             w_drop;
  logic             w_launch;

  // A length of 0 behaves as 1; the counter holds remaining cycles, so load L-1.
  assign w_load = (bus.len == '0) ? '0 : bus.len - 1'b1;

  // Triggers that cannot start or extend a gate right now.
  assign w_nonacc = bus.trig &&
                    (((r_state == S_GATE) && !bus.retrig_en) || (r_state == S_GAP));

`ifdef PULSE_GATE_QUEUE_EN
  assign w_q_full = &r_pend;
`else
  // No queue: treat it as permanently full so every non-accepted trigger drops.
  assign w_q_full = 1'b1;
`endif

  assign w_q_inc  = w_nonacc && !w_q_full;
  assign w_drop   = w_nonacc && w_q_full;
  // Leave the gap straight into a new gate when a trigger is waiting.
  assign w_launch = (r_state == S_GAP) && (r_gap_cnt == '0) && (r_pend != '0);

  // Pending-trigger counter: +1 per queued trigger, -1 per replayed gate.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
    end else begin
      r_pend <= r_pend + Q_W'(w_q_inc) - Q_W'(w_launch);
    end
  end

  // Gate FSM with registered gate/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_gap_cnt    <= '0;
      r_gate       <= 1'b0;
      r_gate_start <= 1'b0;
      r_busy       <= 1'b0;
      r_dropped    <= 1'b0;
    end else begin
      r_gate_start <= 1'b0;
      r_dropped    <= w_drop;
      case (r_state)
        S_IDLE: begin
          if (bus.trig) begin
            r_state      <= S_GATE;
            r_cnt        <= w_load;
            r_gate       <= 1'b1;
            r_gate_start <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        S_GATE: begin
          if (bus.trig && bus.retrig_en) begin
            // Reload counts from this cycle; no new gate_start, no low cycle.
            r_cnt <= w_load;
          end else if (r_cnt == '0) begin
            r_state   <= S_GAP;
            r_gate    <= 1'b0;
            r_gap_cnt <= GAP_LOAD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == '0) begin
            if (w_launch) begin
              r_state      <= S_GATE;
              r_cnt        <= w_load;
              r_gate       <= 1'b1;
              r_gate_start <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gate  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gate       = r_gate;
  assign bus.gate_start = r_gate_start;
  assign bus.busy       = r_busy;
  assign bus.dropped    = r_dropped;

endmodule
